// File: rtl/axis_pkt_injector.sv
// ---------------------------------------------------------------------------
// axis_pkt_injector
// Sends packets from a small programmable table on an AXI-stream master port,
// then counts response packets (beats with TLAST) on an AXI-stream slave port
// until the expected number has arrived.
//
// Optional build macro: INJ_TIMEOUT_EN
//   Adds parameter TMO_CYC and a timeout counter that runs while waiting for
//   responses. When the timeout fires, the run finishes with err=1. When the
//   macro is not defined, err is tied to 0 and the block waits indefinitely.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   cfg_we/addr/...     packet table write port (IDLE or DONE only)
//   start               single-cycle pulse that begins a run
//   num_pkts, exp_rsp   run length and expected responses, sampled on start
//   axis_m_*            injected packet stream (master)
//   axis_s_*            response stream (sink)
//   busy, done, rsp_cnt run status; done is sticky until the next start
//   err                 timeout flag (sticky until the next start)
// ---------------------------------------------------------------------------
module axis_pkt_injector #(
    parameter int unsigned DATAW   = 512,
    parameter int unsigned IDW     = 32,
    parameter int unsigned DESTW   = 12,
    parameter int unsigned USERW   = 75,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDRW   = $clog2(DEPTH),
    parameter int unsigned RSPW    = 16
`ifdef INJ_TIMEOUT_EN
    ,
    parameter int unsigned TMO_CYC = 4096
`endif
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cfg_we,
    input  logic [ADDRW-1:0] cfg_addr,
    input  logic [DATAW-1:0] cfg_data,
    input  logic [DESTW-1:0] cfg_dest,
    input  logic [USERW-1:0] cfg_user,
    input  logic             cfg_last,

    input  logic             start,
    input  logic [ADDRW:0]   num_pkts,
    input  logic [RSPW-1:0]  exp_rsp,

    output logic             axis_m_tvalid,
    input  logic             axis_m_tready,
    output logic [DATAW-1:0] axis_m_tdata,
    output logic             axis_m_tlast,
    output logic [IDW-1:0]   axis_m_tid,
    output logic [USERW-1:0] axis_m_tuser,
    output logic [DESTW-1:0] axis_m_tdest,

    input  logic             axis_s_tvalid,
    output logic             axis_s_tready,
    input  logic             axis_s_tlast,

    output logic             busy,
    output logic             done,
    output logic [RSPW-1:0]  rsp_cnt,
    output logic             err
);

    localparam int unsigned NW = ADDRW + 1;
`ifdef INJ_TIMEOUT_EN
    localparam int unsigned TMOW = $clog2(TMO_CYC + 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;

    // Packet table; intentionally not reset.
    logic [DATAW-1:0] tbl_data [DEPTH];
    logic [DESTW-1:0] tbl_dest [DEPTH];
    logic [USERW-1:0] tbl_user [DEPTH];
    logic             tbl_last [DEPTH];

    logic [NW-1:0]    n_q;        // latched (clamped) packet count
    logic [NW-1:0]    p_q;        // packet pointer
    logic [RSPW-1:0]  exp_q;      // latched expected response count
`ifdef INJ_TIMEOUT_EN
    logic [TMOW-1:0]  tmo_cnt;
`endif

    logic             cfg_ok_c;
    logic [NW-1:0]    num_clamp_c;
    logic [NW-1:0]    p_nxt_c;
    logic [ADDRW-1:0] idx_nxt_c;
    logic             rsp_beat_c;

    // Helper decode for table writes, count clamp and response detection.
    always_comb begin
        cfg_ok_c    = (state == S_IDLE) || (state == S_DONE);
        num_clamp_c = (num_pkts > NW'(DEPTH)) ? NW'(DEPTH) : num_pkts;
        p_nxt_c     = p_q + NW'(1);
        idx_nxt_c   = p_nxt_c[ADDRW-1:0];
        rsp_beat_c  = busy && axis_s_tvalid && axis_s_tlast;
    end

    // The sink is ready exactly while a run is in progress.
    assign axis_s_tready = busy;

    // Table write port; writes are ignored while a run is in progress.
    always_ff @(posedge clk) begin
        if (cfg_we && cfg_ok_c) begin
            tbl_data[cfg_addr] <= cfg_data;
            tbl_dest[cfg_addr] <= cfg_dest;
            tbl_user[cfg_addr] <= cfg_user;
            tbl_last[cfg_addr] <= cfg_last;
        end
    end

    // Run sequencer with registered stream and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            axis_m_tvalid <= 1'b0;
            axis_m_tdata  <= '0;
            axis_m_tlast  <= 1'b0;
            axis_m_tid    <= '0;
            axis_m_tuser  <= '0;
            axis_m_tdest  <= '0;
            n_q           <= '0;
            p_q           <= '0;
            exp_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rsp_cnt       <= '0;
`ifdef INJ_TIMEOUT_EN
            err           <= 1'b0;
            tmo_cnt       <= '0;
`endif
        end else begin
            // Responses count in SEND as well as WAIT; saturate at all-ones.
            if (rsp_beat_c && (rsp_cnt != '1)) begin
                rsp_cnt <= rsp_cnt + RSPW'(1);
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        n_q     <= num_clamp_c;
                        exp_q   <= exp_rsp;
                        p_q     <= '0;
                        rsp_cnt <= '0;
                        done    <= 1'b0;
                        busy    <= 1'b1;
`ifdef INJ_TIMEOUT_EN
                        err     <= 1'b0;
                        tmo_cnt <= '0;
`endif
                        if (num_clamp_c != '0) begin
                            state         <= S_SEND;
                            axis_m_tvalid <= 1'b1;
                            axis_m_tdata  <= tbl_data[0];
                            axis_m_tdest  <= tbl_dest[0];
                            axis_m_tuser  <= tbl_user[0];
                            axis_m_tlast  <= tbl_last[0];
                            axis_m_tid    <= '0;
                        end else if (exp_rsp == '0) begin
                            // Nothing to send and nothing to wait for.
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end

                S_SEND: begin
                    // Payload only changes on a handshake, so it is held while stalled.
                    if (axis_m_tready) begin
                        if (p_q == (n_q - NW'(1))) begin
                            axis_m_tvalid <= 1'b0;
                            state         <= S_WAIT;
                        end else begin
                            p_q          <= p_nxt_c;
                            axis_m_tid   <= IDW'(p_nxt_c);
                            axis_m_tdata <= tbl_data[idx_nxt_c];
                            axis_m_tdest <= tbl_dest[idx_nxt_c];
                            axis_m_tuser <= tbl_user[idx_nxt_c];
                            axis_m_tlast <= tbl_last[idx_nxt_c];
                        end
                    end
                end

                S_WAIT: begin
                    // Evaluated on the registered count; >= covers early responses.
                    if (rsp_cnt >= exp_q) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`ifdef INJ_TIMEOUT_EN
                    end else if (rsp_beat_c) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMOW'(TMO_CYC - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMOW'(1);
`endif
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef INJ_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule
